rx_interface: RTL and testbench

Lane receive front end for the Interlaken link: accepts 64-bit words with 2-bit sync headers from the gearbox, acquires block lock, and requests bit slips from the gearbox until lock is acquired. Once block locked, it tracks the meta-frame by its sync control word and forwards data words to the lane decoder with a one-cycle registered latency. It is the receive-side counterpart of the lane `tx_interface`.

---
 rtl/interlaken_pkg.sv | 33 +++
 rtl/rx_interface_if.sv | 29 ++
 rtl/rx_block_lock.sv | 143 ++++++++++++++
 rtl/rx_interface.sv | 144 ++++++++++++++
 tb/tb_rx_interface.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/interlaken_pkg.sv
// Shared Interlaken lane definitions: header codes, sync pattern, frame-lock
// thresholds, state encodings and small word-classification helpers.
package interlaken_pkg;

    localparam logic [1:0] HDR_DATA     = 2'b01;
    localparam logic [1:0] HDR_CTRL     = 2'b10;
    localparam logic [5:0] SYNC_PATTERN = 6'b011110;

    localparam int unsigned FRAME_MATCH_CNT = 4;
    localparam int unsigned FRAME_MISS_CNT  = 3;

    typedef enum logic [1:0] {
        ST_HUNT      = 2'd0,
        ST_SLIP_WAIT = 2'd1,
        ST_LOCKED    = 2'd2
    } block_state_e;

    typedef enum logic [1:0] {
        F_HUNT   = 2'd0,
        F_CHECK  = 2'd1,
        F_LOCKED = 2'd2
    } frame_state_e;

    // 00 and 11 are not legal sync headers
    function automatic logic hdr_is_valid(input logic [1:0] hdr);
        return (hdr == HDR_DATA) || (hdr == HDR_CTRL);
    endfunction

    function automatic logic is_sync_word(input logic [1:0] hdr, input logic [63:0] data);
        return (hdr == HDR_CTRL) && (data[63:58] == SYNC_PATTERN);
    endfunction

endpackage

// File: rtl/rx_interface_if.sv
// Lane receive bus: gearbox-facing inputs, slip request and the decoder-facing
// forwarded word with lock status. master drives the gearbox side, slave is rx_interface.
interface rx_interface_if;

    logic [63:0] DATA_IN;
    logic [1:0]  HEADER_IN;
    logic        DATA_VALID_IN;
    logic        SLIP;
    logic        BLOCK_LOCK;
    logic        FRAME_LOCK;
    logic [63:0] DATA_OUT;
    logic [1:0]  HEADER_OUT;
    logic        DATA_VALID_OUT;
    logic        SYNC_WORD_OUT;
    logic [15:0] ERR_COUNT;

    modport master (
        output DATA_IN, HEADER_IN, DATA_VALID_IN,
        input  SLIP, BLOCK_LOCK, FRAME_LOCK, DATA_OUT, HEADER_OUT,
        input  DATA_VALID_OUT, SYNC_WORD_OUT, ERR_COUNT
    );

    modport slave (
        input  DATA_IN, HEADER_IN, DATA_VALID_IN,
        output SLIP, BLOCK_LOCK, FRAME_LOCK, DATA_OUT, HEADER_OUT,
        output DATA_VALID_OUT, SYNC_WORD_OUT, ERR_COUNT
    );

endinterface

// File: rtl/rx_block_lock.sv
// Block lock state machine: hunts for LOCK_CNT consecutive valid headers,
// requests bit slips on bad headers, and drops lock after ERR_MAX bad headers
// in an ERR_WINDOW-word window. Optional lifetime error counter under RX_ERR_CNT_EN.
module rx_block_lock
    import interlaken_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = 64,
    parameter int unsigned ERR_WINDOW = 64,
    parameter int unsigned ERR_MAX    = 16,
    parameter int unsigned SLIP_WAIT  = 32
) (
    input  logic        USER_CLK,
    input  logic        SYSTEM_RESET,
    input  logic        valid_in,
    input  logic        hdr_ok,
    output logic        slip,
    output logic        block_lock,
    output logic        lock_loss,
    output logic [15:0] err_count
);

    // One counter serves both the HUNT run length and the SLIP_WAIT holdoff
    localparam int unsigned CntMax = (LOCK_CNT > SLIP_WAIT) ? LOCK_CNT : SLIP_WAIT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned WinW   = (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;
    localparam int unsigned ErrW   = $clog2(ERR_MAX + 1);

    localparam logic [CntW-1:0] LockCntC  = CntW'(LOCK_CNT);
    localparam logic [CntW-1:0] SlipWaitC = CntW'(SLIP_WAIT);
    localparam logic [WinW-1:0] WinLastC  = WinW'(ERR_WINDOW - 1);
    localparam logic [ErrW-1:0] ErrMaxC   = ErrW'(ERR_MAX);

    block_state_e    state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [WinW-1:0] win_q, win_d;
    logic [ErrW-1:0] err_q, err_d;
    logic [ErrW-1:0] err_next;
    logic            slip_q, slip_d;
    logic            lock_q, lock_d;

    // Next-state for the block machine and its run/window/error counters
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        win_d    = win_q;
        err_d    = err_q;
        slip_d   = 1'b0;
        lock_d   = lock_q;
        err_next = err_q + (hdr_ok ? '0 : ErrW'(1));

        if (valid_in) begin
            case (state_q)
                ST_HUNT: begin
                    if (!hdr_ok) begin
                        slip_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_SLIP_WAIT;
                    end else if (cnt_q + 1'b1 == LockCntC) begin
                        cnt_d   = '0;
                        win_d   = '0;
                        err_d   = '0;
                        lock_d  = 1'b1;
                        state_d = ST_LOCKED;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_SLIP_WAIT: begin
                    // Gearbox is realigning; headers are meaningless here
                    if (cnt_q + 1'b1 == SlipWaitC) begin
                        cnt_d   = '0;
                        state_d = ST_HUNT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (err_next == ErrMaxC) begin
                        slip_d  = 1'b1;
                        lock_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_SLIP_WAIT;
                    end else if (win_q == WinLastC) begin
                        // Wrapping word starts the next window's tally
                        win_d = '0;
                        err_d = hdr_ok ? '0 : ErrW'(1);
                    end else begin
                        win_d = win_q + 1'b1;
                        err_d = err_next;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    cnt_d   = '0;
                    lock_d  = 1'b0;
                end
            endcase
        end
    end

    // Block machine state and registered SLIP / BLOCK_LOCK outputs
    always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
        if (SYSTEM_RESET) begin
            state_q <= ST_HUNT;
            cnt_q   <= '0;
            win_q   <= '0;
            err_q   <= '0;
            slip_q  <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            err_q   <= err_d;
            slip_q  <= slip_d;
            lock_q  <= lock_d;
        end
    end

    assign slip       = slip_q;
    assign block_lock = lock_q;
    // Lets the frame tracker drop to F_HUNT on the same edge lock is lost
    assign lock_loss  = lock_q & ~lock_d;

`ifdef RX_ERR_CNT_EN
    logic [15:0] err_total_q;

    // Lifetime saturating count of bad headers outside the slip holdoff
    always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
        if (SYSTEM_RESET) begin
            err_total_q <= 16'h0;
        end else if (valid_in && !hdr_ok && (state_q != ST_SLIP_WAIT) &&
                     (err_total_q != 16'hFFFF)) begin
            err_total_q <= err_total_q + 16'h1;
        end
    end

    assign err_count = err_total_q;
`else
    assign err_count = 16'h0;
`endif

endmodule

// File: rtl/rx_interface.sv
// Interlaken lane receive front end: block lock (rx_block_lock), meta-frame
// tracking on the sync control word, and registered one-cycle word forwarding.
// Define RX_ERR_CNT_EN to enable the lifetime ERR_COUNT counter.
module rx_interface
    import interlaken_pkg::*;
#(
    parameter int unsigned META_FRAME_LEN = 16,
    parameter int unsigned LOCK_CNT       = 64,
    parameter int unsigned ERR_WINDOW     = 64,
    parameter int unsigned ERR_MAX        = 16,
    parameter int unsigned SLIP_WAIT      = 32
) (
    input logic           USER_CLK,
    input logic           SYSTEM_RESET,
    rx_interface_if.slave rx
);

    localparam int unsigned PosW = $clog2(META_FRAME_LEN);

    logic block_lock;
    logic lock_loss;

    rx_block_lock #(
        .LOCK_CNT   (LOCK_CNT),
        .ERR_WINDOW (ERR_WINDOW),
        .ERR_MAX    (ERR_MAX),
        .SLIP_WAIT  (SLIP_WAIT)
    ) u_block_lock (
        .USER_CLK     (USER_CLK),
        .SYSTEM_RESET (SYSTEM_RESET),
        .valid_in     (rx.DATA_VALID_IN),
        .hdr_ok       (hdr_is_valid(rx.HEADER_IN)),
        .slip         (rx.SLIP),
        .block_lock   (block_lock),
        .lock_loss    (lock_loss),
        .err_count    (rx.ERR_COUNT)
    );

    frame_state_e    fstate_q, fstate_d;
    logic [PosW-1:0] pos_q, pos_d;
    logic [2:0]      match_q, match_d;
    logic [1:0]      miss_q, miss_d;
    logic            frame_lock_q;
    logic [63:0]     data_q;
    logic [1:0]      header_q;
    logic            valid_q;
    logic            sync_out_q, sync_out_d;
    logic            step;
    logic            sync_now;

    assign step     = block_lock & rx.DATA_VALID_IN;
    assign sync_now = is_sync_word(rx.HEADER_IN, rx.DATA_IN);

    // Next-state for meta-frame tracking; only forwarded words advance it
    always_comb begin
        fstate_d   = fstate_q;
        pos_d      = pos_q;
        match_d    = match_q;
        miss_d     = miss_q;
        sync_out_d = 1'b0;

        if (step && (pos_q == '0) && sync_now &&
            ((fstate_q == F_CHECK) || (fstate_q == F_LOCKED))) begin
            sync_out_d = 1'b1;
        end

        if (lock_loss) begin
            // Overrides any sync word arriving on the losing word
            fstate_d = F_HUNT;
            match_d  = '0;
            miss_d   = '0;
        end else if (step) begin
            pos_d = pos_q + 1'b1;
            case (fstate_q)
                F_HUNT: begin
                    if (sync_now) begin
                        pos_d    = PosW'(1);
                        match_d  = 3'd1;
                        fstate_d = F_CHECK;
                    end
                end
                F_CHECK: begin
                    if (pos_q == '0) begin
                        if (!sync_now) begin
                            fstate_d = F_HUNT;
                        end else if (match_q + 3'd1 == 3'(FRAME_MATCH_CNT)) begin
                            match_d  = match_q + 3'd1;
                            miss_d   = '0;
                            fstate_d = F_LOCKED;
                        end else begin
                            match_d = match_q + 3'd1;
                        end
                    end
                end
                F_LOCKED: begin
                    if (pos_q == '0) begin
                        if (sync_now) begin
                            miss_d = '0;
                        end else if (miss_q + 2'd1 == 2'(FRAME_MISS_CNT)) begin
                            miss_d   = '0;
                            fstate_d = F_HUNT;
                        end else begin
                            miss_d = miss_q + 2'd1;
                        end
                    end
                end
                default: fstate_d = F_HUNT;
            endcase
        end
    end

    // Frame state and the registered forwarding outputs
    always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
        if (SYSTEM_RESET) begin
            fstate_q     <= F_HUNT;
            pos_q        <= '0;
            match_q      <= '0;
            miss_q       <= '0;
            frame_lock_q <= 1'b0;
            data_q       <= 64'h0;
            header_q     <= 2'b00;
            valid_q      <= 1'b0;
            sync_out_q   <= 1'b0;
        end else begin
            fstate_q     <= fstate_d;
            pos_q        <= pos_d;
            match_q      <= match_d;
            miss_q       <= miss_d;
            frame_lock_q <= (fstate_d == F_LOCKED);
            data_q       <= step ? rx.DATA_IN : 64'h0;
            header_q     <= step ? rx.HEADER_IN : 2'b00;
            valid_q      <= step;
            sync_out_q   <= sync_out_d;
        end
    end

    assign rx.BLOCK_LOCK     = block_lock;
    assign rx.FRAME_LOCK     = frame_lock_q;
    assign rx.DATA_OUT       = data_q;
    assign rx.HEADER_OUT     = header_q;
    assign rx.DATA_VALID_OUT = valid_q;
    assign rx.SYNC_WORD_OUT  = sync_out_q;

endmodule

// File: tb/tb_rx_interface.sv
// Directed bench for rx_interface: lock acquisition, slip holdoff, error
// window, meta-frame lock/miss handling and asynchronous reset.
module tb_rx_interface;

    localparam logic [1:0]  HD = 2'b01;
    localparam logic [1:0]  HC = 2'b10;
    localparam logic [1:0]  HBAD = 2'b11;
    localparam logic [63:0] SYNC_W = {6'b011110, 58'h0123_4567_89AB};

    logic USER_CLK = 1'b0;
    logic SYSTEM_RESET;

    int n_checks = 0;
    int n_errors = 0;
    int win_cnt  = 0;
    int slip_cnt = 0;
    logic sync_seen;
    logic fl_seen;
    logic [15:0] exp_err;

    rx_interface_if bus ();

    rx_interface #(
        .META_FRAME_LEN (16),
        .LOCK_CNT       (64),
        .ERR_WINDOW     (64),
        .ERR_MAX        (16),
        .SLIP_WAIT      (32)
    ) dut (
        .USER_CLK     (USER_CLK),
        .SYSTEM_RESET (SYSTEM_RESET),
        .rx           (bus)
    );

    always #5 USER_CLK = ~USER_CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Present one input cycle, then sample just after the edge
    task automatic send(input logic v, input logic [1:0] h, input logic [63:0] d);
        bus.DATA_VALID_IN = v;
        bus.HEADER_IN     = h;
        bus.DATA_IN       = d;
        @(posedge USER_CLK);
        #1;
        if (bus.SLIP) slip_cnt++;
        if (v) win_cnt++;
    endtask

    // One 16-word meta-frame; first word is a sync word or plain data
    task automatic frame(input logic with_sync);
        send(1'b1, with_sync ? HC : HD, with_sync ? SYNC_W : 64'h5555_0000);
        sync_seen = bus.SYNC_WORD_OUT;
        fl_seen   = bus.FRAME_LOCK;
        for (int k = 1; k < 16; k++) send(1'b1, HD, 64'h5555_0000 + 64'(k));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_slip"}, {63'h0, bus.SLIP}, 64'h0);
        check({tag, "_blk"},  {63'h0, bus.BLOCK_LOCK}, 64'h0);
        check({tag, "_frm"},  {63'h0, bus.FRAME_LOCK}, 64'h0);
        check({tag, "_data"}, bus.DATA_OUT, 64'h0);
        check({tag, "_hdr"},  {62'h0, bus.HEADER_OUT}, 64'h0);
        check({tag, "_dv"},   {63'h0, bus.DATA_VALID_OUT}, 64'h0);
        check({tag, "_sync"}, {63'h0, bus.SYNC_WORD_OUT}, 64'h0);
        check({tag, "_errc"}, {48'h0, bus.ERR_COUNT}, 64'h0);
    endtask

    initial begin
        SYSTEM_RESET      = 1'b1;
        bus.DATA_IN       = 64'h0;
        bus.HEADER_IN     = 2'b00;
        bus.DATA_VALID_IN = 1'b0;
        #12;
        check_all_zero("reset");
        @(posedge USER_CLK);
        #1;
        SYSTEM_RESET = 1'b0;

        // Lock acquisition with DATA_VALID_IN toggling every other cycle
        for (int i = 0; i < 64; i++) begin
            send(1'b1, HD, 64'hA000 + 64'(i));
            if (i == 62) check("lock_after_63", {63'h0, bus.BLOCK_LOCK}, 64'h0);
            if (i == 63) begin
                check("lock_after_64", {63'h0, bus.BLOCK_LOCK}, 64'h1);
                check("dv_word64", {63'h0, bus.DATA_VALID_OUT}, 64'h0);
            end
            send(1'b0, HC, 64'hFFFF_FFFF);
            if (i == 10) check("idle_data", bus.DATA_OUT, 64'h0);
            if (i == 40) check("lock_half_cycles", {63'h0, bus.BLOCK_LOCK}, 64'h0);
        end
        win_cnt = 0;

        send(1'b1, HC, 64'hDEAD_BEEF_0000_0001);
        check("fwd_data", bus.DATA_OUT, 64'hDEAD_BEEF_0000_0001);
        check("fwd_hdr", {62'h0, bus.HEADER_OUT}, 64'h2);
        check("fwd_dv", {63'h0, bus.DATA_VALID_OUT}, 64'h1);

        // Meta-frame lock: four syncs 16 words apart
        frame(1'b1);
        check("sync_in_hunt", {63'h0, sync_seen}, 64'h0);
        frame(1'b1);
        check("sync_in_check", {63'h0, sync_seen}, 64'h1);
        frame(1'b1);
        check("frm_after_3", {63'h0, fl_seen}, 64'h0);
        frame(1'b1);
        check("frm_after_4", {63'h0, fl_seen}, 64'h1);

        // Two misses hold, a sync resets the tally, three misses drop
        frame(1'b0);
        check("miss_no_sync", {63'h0, sync_seen}, 64'h0);
        frame(1'b0);
        check("frm_2_miss", {63'h0, bus.FRAME_LOCK}, 64'h1);
        frame(1'b1);
        check("frm_resync", {63'h0, bus.FRAME_LOCK}, 64'h1);
        frame(1'b0);
        frame(1'b0);
        check("frm_2_miss_b", {63'h0, fl_seen}, 64'h1);
        frame(1'b0);
        check("frm_3_miss", {63'h0, fl_seen}, 64'h0);

        // Align to an error-window boundary
        while ((win_cnt % 64) != 0) send(1'b1, HD, 64'h77);
        slip_cnt = 0;
        for (int i = 0; i < 15; i++) send(1'b1, HBAD, 64'h88);
        for (int i = 0; i < 49; i++) send(1'b1, HD, 64'h99);
        check("lock_15_err", {63'h0, bus.BLOCK_LOCK}, 64'h1);
        check("no_slip_15_err", 64'(slip_cnt), 64'h0);

        for (int i = 0; i < 16; i++) begin
            send(1'b1, HBAD, 64'hBB);
            if (i == 14) check("lock_15_of_16", {63'h0, bus.BLOCK_LOCK}, 64'h1);
        end
        check("slip_16_err", {63'h0, bus.SLIP}, 64'h1);
        check("lock_lost", {63'h0, bus.BLOCK_LOCK}, 64'h0);
        check("dv_on_loss_word", {63'h0, bus.DATA_VALID_OUT}, 64'h1);
        send(1'b1, HD, 64'hCC);
        check("dv_after_loss", {63'h0, bus.DATA_VALID_OUT}, 64'h0);
        check("slip_one_cycle", {63'h0, bus.SLIP}, 64'h0);

        // Rest of the holdoff, with a bad header that must be ignored
        slip_cnt = 0;
        for (int i = 0; i < 31; i++) send(1'b1, (i == 5) ? HBAD : HD, 64'hDD);
        check("holdoff_no_slip", 64'(slip_cnt), 64'h0);

        // Bad header at word 10 of HUNT
        for (int i = 0; i < 9; i++) send(1'b1, HD, 64'hEE);
        send(1'b1, HBAD, 64'hEF);
        check("hunt_slip", {63'h0, bus.SLIP}, 64'h1);
        for (int i = 0; i < 32; i++) send(1'b1, (i == 3) ? 2'b00 : HD, 64'hF0);
        check("one_slip_per_wait", 64'(slip_cnt), 64'h1);

        // Count restarts from zero after the holdoff
        for (int i = 0; i < 63; i++) send(1'b1, HD, 64'h100 + 64'(i));
        check("relock_63", {63'h0, bus.BLOCK_LOCK}, 64'h0);
        send(1'b1, HD, 64'h200);
        check("relock_64", {63'h0, bus.BLOCK_LOCK}, 64'h1);
        send(1'b1, HD, 64'h0BAD_CAFE_1234_5678);
        check("relock_fwd", bus.DATA_OUT, 64'h0BAD_CAFE_1234_5678);

`ifdef RX_ERR_CNT_EN
        exp_err = 16'd32;
`else
        exp_err = 16'd0;
`endif
        check("err_count", {48'h0, bus.ERR_COUNT}, {48'h0, exp_err});

        // Reach F_LOCKED again, then reset between edges
        for (int f = 0; f < 4; f++) frame(1'b1);
        check("frm_before_rst", {63'h0, bus.FRAME_LOCK}, 64'h1);
        send(1'b1, HC, SYNC_W);
        #2;
        SYSTEM_RESET = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(posedge USER_CLK);
        #1;
        SYSTEM_RESET = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
